// File: rtl/ext_data_memory.sv
// Fixed-latency 256-bit line memory that serves L1 refills and writebacks, one transaction at a time.
// Optional feature macro EXT_MEM_ACCESS_CNT_EN adds read/write completion counters.
module ext_data_memory #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512,
    parameter int LINE_W  = 256,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              cs_i,
    input  logic              we_i,
    input  logic [LINE_W-1:0] data_i,
    output logic [LINE_W-1:0] data_o,
    output logic              ack_o
`ifdef EXT_MEM_ACCESS_CNT_EN
    ,
    output logic [31:0]       rd_cnt_o,
    output logic [31:0]       wr_cnt_o
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_ACK
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic                r_we;
    logic [LINE_W-1:0]   r_wdata;
    logic [LINE_W-1:0]   r_rdata;
    logic                r_ack;
    logic [LINE_W-1:0]   r_mem [DEPTH];

    logic [IDX_W-1:0]    w_idx;
    logic                w_accept;
    logic                w_done;
    logic                w_unused;

    // Byte offset and bits above the line index are don't-care.
    assign w_idx    = addr_i[5 +: IDX_W];
    assign w_unused = ^{addr_i[ADDR_W-1:5+IDX_W], addr_i[4:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (cs_i) w_next = S_BUSY;
            S_BUSY:  if (r_cnt == 8'd0) w_next = S_ACK;
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept = 1'b0;
        w_done   = 1'b0;
        unique case (r_state)
            S_IDLE:  w_accept = cs_i;
            S_BUSY:  w_done   = (r_cnt == 8'd0);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 8'd0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= w_done;
            if (w_accept) begin
                r_cnt <= 8'(LATENCY - 1);
            end else if (r_state == S_BUSY && r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_done && !r_we) begin
                r_rdata <= r_mem[r_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_idx   <= w_idx;
            r_we    <= we_i;
            r_wdata <= data_i;
        end
    end

    // A reset on the completing edge abandons the write.
    always_ff @(posedge clk) begin
        if (!rst && w_done && r_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

`ifdef EXT_MEM_ACCESS_CNT_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_cnt <= 32'd0;
            r_wr_cnt <= 32'd0;
        end else if (w_done) begin
            if (r_we) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end else begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
        end
    end

    assign rd_cnt_o = r_rd_cnt;
    assign wr_cnt_o = r_wr_cnt;
`endif

    assign data_o = r_rdata;
    assign ack_o  = r_ack;

endmodule
